// File: rtl/gf_2to4_frobenius_engine.sv
// Iterative GF(2^4) Frobenius engine: y = x^(2^k), one squaring per clock.
// A single squarer sits on the data register and its output recirculates
// until the requested number of squarings has been applied.

// Combinational GF(2^4) squaring map (bit 3 = MSB).
module gf_2to4_squarer (
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  // Squaring in GF(2^4) is linear over GF(2), so it reduces to four XOR terms.
  always_comb begin
    o_y[3] = i_x[3];
    o_y[2] = i_x[3] ^ i_x[2];
    o_y[1] = i_x[2] ^ i_x[1];
    o_y[0] = i_x[3] ^ i_x[1] ^ i_x[0];
  end

endmodule

module gf_2to4_frobenius_engine #(
  parameter int unsigned NB_DATA = 4,
  parameter int unsigned NB_K    = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_x,
  input  logic [NB_K-1:0]    i_k,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_y,
  input  logic               i_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_K-1:0]    cnt_q, cnt_d;
  logic [NB_DATA-1:0] sq_data;
  logic               accept;

  gf_2to4_squarer u_squarer (
    .i_x (data_q),
    .o_y (sq_data)
  );

  assign accept = (state_q == ST_IDLE) && i_valid;

  // State register; reset discards any in-flight request.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operand/count capture and the recirculating square.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state logic; the spare encoding falls back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (i_k == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // cnt_q counts squarings still to perform, including this cycle's.
        state_d = (cnt_q == NB_K'(1)) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        state_d = i_ready ? ST_IDLE : ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: load on accept, square while running, else hold.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d = i_x;
          cnt_d  = i_k;
        end
      end
      ST_RUN: begin
        data_d = sq_data;
        cnt_d  = cnt_q - NB_K'(1);
      end
      default: begin
        data_d = data_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  // Outputs decode from state only; no combinational path from the inputs.
  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_valid = (state_q == ST_DONE);
    o_y     = data_q;
  end

endmodule

// File: tb/tb_gf_2to4_frobenius_engine.sv
// Directed and randomized checks of the GF(2^4) Frobenius engine.
module tb_gf_2to4_frobenius_engine;

  logic       i_clock;
  logic       i_reset_n;
  logic       i_valid;
  logic [3:0] i_x;
  logic [3:0] i_k;
  logic       o_ready;
  logic       o_valid;
  logic [3:0] o_y;
  logic       i_ready;

  int checks;
  int failures;

  gf_2to4_frobenius_engine #(
    .NB_DATA (4),
    .NB_K    (4)
  ) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid),
    .i_x       (i_x),
    .i_k       (i_k),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_y       (o_y),
    .i_ready   (i_ready)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [3:0] x;
    logic [3:0] k;
    logic [3:0] y;
    int         stall;
    bit         noise;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sq(input logic [3:0] a);
    logic [3:0] r;
    r[3] = a[3];
    r[2] = a[3] ^ a[2];
    r[1] = a[2] ^ a[1];
    r[0] = a[3] ^ a[1] ^ a[0];
    return r;
  endfunction

  function automatic logic [3:0] frob(input logic [3:0] a, input logic [3:0] k);
    logic [3:0] r;
    r = a;
    for (int i = 0; i < int'(k); i++) r = sq(r);
    return r;
  endfunction

  // Called at a negedge. Issues one request and checks latency, value,
  // backpressure hold and the o_ready return.
  task automatic run_req(input logic [3:0] x, input logic [3:0] k, input logic [3:0] exp,
                         input int stall, input bit noise, input string name);
    int lat;
    bit seen;
    chk({name, "_ready_before"}, {31'd0, o_ready}, 32'd1);
    i_ready = (stall == 0);
    i_valid = 1'b1;
    i_x     = x;
    i_k     = k;
    @(posedge i_clock);
    #1;
    i_valid = noise;
    i_x     = 4'($urandom);
    i_k     = 4'($urandom);
    lat  = 0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge i_clock);
      lat++;
      if (o_valid) begin
        seen = 1;
      end else begin
        chk({name, "_ready_busy"}, {31'd0, o_ready}, 32'd0);
        i_x = 4'($urandom);
        i_k = 4'($urandom);
      end
    end
    chk({name, "_valid_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_latency"}, lat, int'(k) + 1);
    chk({name, "_y"}, {28'd0, o_y}, {28'd0, exp});
    for (int s = 0; s < stall; s++) begin
      i_x = 4'($urandom);
      i_k = 4'($urandom);
      @(negedge i_clock);
      chk({name, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
      chk({name, "_hold_y"}, {28'd0, o_y}, {28'd0, exp});
      chk({name, "_hold_ready"}, {31'd0, o_ready}, 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clock);
    chk({name, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
    chk({name, "_ready_back"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] rx;
    logic [3:0] rk;
    bit         stale;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{4'b1000, 4'd1,  4'b1101, 0,  1'b0};
    vecs[1]  = '{4'b1000, 4'd3,  4'b1110, 0,  1'b0};
    vecs[2]  = '{4'b1000, 4'd4,  4'b1000, 2,  1'b0};
    vecs[3]  = '{4'b1011, 4'd0,  4'b1011, 0,  1'b0};
    vecs[4]  = '{4'b0001, 4'd15, 4'b0001, 0,  1'b0};
    vecs[5]  = '{4'b0010, 4'd5,  4'b0011, 3,  1'b0};
    vecs[6]  = '{4'b0100, 4'd2,  4'b0101, 0,  1'b0};
    vecs[7]  = '{4'b1011, 4'd2,  4'b1001, 1,  1'b0};
    vecs[8]  = '{4'b1100, 4'd7,  4'b1001, 0,  1'b0};
    vecs[9]  = '{4'b0000, 4'd9,  4'b0000, 0,  1'b0};
    vecs[10] = '{4'b1101, 4'd14, 4'b1110, 2,  1'b0};
    vecs[11] = '{4'b0111, 4'd15, 4'b0101, 0,  1'b0};
    vecs[12] = '{4'b1000, 4'd4,  4'b1000, 10, 1'b1};

    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_x       = '0;
    i_k       = '0;
    i_ready   = 1'b1;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_y", {28'd0, o_y}, 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clock);

    for (int i = 0; i < 13; i++) begin
      run_req(vecs[i].x, vecs[i].k, vecs[i].y, vecs[i].stall, vecs[i].noise,
              $sformatf("vec%0d", i));
      $display("vec%0d x=%b k=%0d y=%b", i, vecs[i].x, vecs[i].k, o_y);
    end

    // Reset in the middle of a long run discards the request.
    i_valid = 1'b1;
    i_x     = 4'b1000;
    i_k     = 4'd12;
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    repeat (4) @(negedge i_clock);
    i_reset_n = 1'b0;
    @(negedge i_clock);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_y", {28'd0, o_y}, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    i_reset_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clock);
      if (o_valid) stale = 1;
    end
    chk("midrst_no_stale", {31'd0, stale}, 32'd0);
    run_req(4'b0110, 4'd1, 4'b0101, 0, 1'b0, "post_rst");
    $display("post_rst x=0110 k=1 y=%b", o_y);

    // Randomized regression against the reference model.
    for (int i = 0; i < 300; i++) begin
      rx = 4'($urandom);
      rk = 4'($urandom);
      run_req(rx, rk, frob(rx, rk), int'($urandom_range(0, 3)), 1'($urandom),
              $sformatf("rnd%0d", i));
      $display("rnd%0d x=%b k=%0d y=%b", i, rx, rk, o_y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
